idx_to_coord: RTL and testbench
===============================

# idx_to_coord

OLED pixel-addressing helper for the 96x64 display path. Generates a programmable divided clock (the OLED pixel clock and slow tick clocks) from the board clock. Converts the display driver's linear pixel index into column/row coordinates consumed by drawing logic. Sits between the OLED driver and every screen renderer (menu, game screens).

## Interface

- `WIDTH`, default 96: display columns.
- `HEIGHT`, default 64: display rows.
- `CNT_W`, default 32: divider count width.

Ports (one clock; reset is synchronous and active-high):

- `clock` in 1: board clock (100 MHz).
- `reset` in 1: synchronous, active-high; clears divider state and output registers.
- `count_in` in CNT_W: divider terminal count; half-period = count_in+1 clock cycles.
- `pix_index` in 13: linear pixel index from the OLED driver, row-major.
- `out_clk` out 1: divided clock, 50% duty.
- `x` out 13: column = pix_index mod WIDTH.
- `y` out 13: row = pix_index div WIDTH.
- `valid` out 1: high when pix_index < WIDTH*HEIGHT (6144).

## Operation

- Divider:
  - Counter `cnt` increments every `clock`.
  - When `cnt >= count_in`: `cnt` <= 0 and `out_clk` toggles. Otherwise `cnt` <= `cnt`+1.
  - `out_clk` frequency = f_clock / (2*(count_in+1)).
  - Required uses: count_in=7 gives 6.25 MHz; count_in=249_999 gives 200 Hz (5 ms period).
- The `>=` compare is mandatory. If count_in is lowered below the current `cnt`, the divider wraps on the next edge with no 2^32 run-out.
- count_in=0: `out_clk` toggles every cycle (f/2).
- Coordinates:
  - x = pix_index % WIDTH; y = pix_index / WIDTH. Unsigned, zero-extended to 13 bits.
  - Division is by a constant. It may be implemented as a constant multiply-shift or by comparison, but results must be exact for all 8192 inputs.
- Out-of-range indices (6144..8191): x and y still follow the formulas (y up to 85); `valid`=0.

## Timing

- Reset values: `cnt`=0, `out_clk`=0. With IDX_TO_COORD_REG_EN, also x=0, y=0, `valid`=0.
- Reset mid-count: the next edge after reset deasserts starts from `cnt`=0. The first toggle occurs count_in+1 cycles after reset release.
- `out_clk` first rises at cycle count_in+1 after reset. It then toggles every count_in+1 cycles.
- A change on count_in takes effect on the next compare; there is no glitch beyond the truncated or extended current half-period.
- Default coordinate path is combinational (zero latency) from pix_index to x, y and `valid`.

## Configuration

- `IDX_TO_COORD_REG_EN` defined: x, y and `valid` are registered on `clock`, giving 1-cycle latency. They are cleared by reset.
- `IDX_TO_COORD_REG_EN` undefined: purely combinational coordinate path. `reset` affects only the divider.

## Structure

- Shared package `oled_pkg`:
  - OLED_WIDTH=96, OLED_HEIGHT=64, PIX_COUNT=6144, PIX_IDX_W=13, COORD_W=13.
  - Standard divider counts: CNT_6P25M=7, CNT_200HZ=249_999.
- One sub-module: `flexible_clock`, the divider.
  - Ports: `basys_clk`, `reset`, `count_in`, `out_clk`.
  - Instantiated once.
- The coordinate conversion lives in the top level.

## Test plan

- Reset, count_in=7: `out_clk` held 0 during reset; then toggles every 8 cycles, giving a 16-cycle period.
- count_in=0: `out_clk` toggles every cycle. Switch count_in from 100 to 3 while `cnt`=50: toggle on the next edge, then every 4 cycles.
- pix_index=0 -> x=0, y=0, valid=1. pix_index=95 -> x=95, y=0. pix_index=96 -> x=0, y=1. pix_index=6143 -> x=95, y=63, valid=1.
- pix_index=6144 -> x=0, y=64, valid=0. pix_index=8191 -> x=31, y=85, valid=0.
- Exhaustive sweep 0..8191 versus the mod/div model. With IDX_TO_COORD_REG_EN, check 1-cycle latency and x=y=0 after reset.
- Assert reset mid-half-period with count_in=249_999: `cnt` and `out_clk` return to 0. The first toggle occurs 250_000 cycles after release.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants for the 96x64 OLED display path.
// Provides the display geometry, index/coordinate widths and the standard
// divider terminal counts used to derive the pixel clock and slow ticks.
package oled_pkg;

  localparam int unsigned OLED_WIDTH  = 96;
  localparam int unsigned OLED_HEIGHT = 64;
  localparam int unsigned PIX_COUNT   = OLED_WIDTH * OLED_HEIGHT;  // 6144
  localparam int unsigned PIX_IDX_W   = 13;
  localparam int unsigned COORD_W     = 13;

  // Divider terminal counts for a 100 MHz board clock: f = 100e6 / (2*(n+1)).
  localparam int unsigned CNT_6P25M = 7;
  localparam int unsigned CNT_200HZ = 249_999;

endpackage

// File: rtl/idx_to_coord_if.sv
// Pixel coordinate bus between the OLED driver and the renderers.
//   pix_index : linear row-major pixel index from the driver
//   x, y      : column / row derived from pix_index
//   valid     : pix_index lies inside the visible frame
// Modports:
//   master : the OLED driver side (drives pix_index, consumes coordinates)
//   slave  : the converter side (consumes pix_index, drives coordinates)
interface idx_to_coord_if;
  import oled_pkg::*;

  logic [PIX_IDX_W-1:0] pix_index;
  logic [COORD_W-1:0]   x;
  logic [COORD_W-1:0]   y;
  logic                 valid;

  modport master (
    output pix_index,
    input  x,
    input  y,
    input  valid
  );

  modport slave (
    input  pix_index,
    output x,
    output y,
    output valid
  );

endinterface

// File: rtl/flexible_clock.sv
// Programmable clock divider.
//   basys_clk : board clock
//   reset     : synchronous, active-high; clears the counter and out_clk
//   count_in  : terminal count; each half-period lasts count_in+1 cycles
//   out_clk   : divided clock, 50% duty, f = f_clk / (2*(count_in+1))
module flexible_clock #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             basys_clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  output logic             out_clk
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_clk_q, out_clk_d;
  logic             wrap;

  // ">=" rather than "==": lowering count_in below the running count must
  // wrap on the next edge instead of running the counter out to 2^CNT_W.
  assign wrap = (cnt_q >= count_in);

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    out_clk_d = out_clk_q;
    if (wrap) begin
      cnt_d     = '0;
      out_clk_d = ~out_clk_q;
    end
  end

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      cnt_q     <= '0;
      out_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      out_clk_q <= out_clk_d;
    end
  end

  assign out_clk = out_clk_q;

endmodule

// File: rtl/idx_to_coord.sv
// OLED pixel-addressing helper.
// Divides the board clock to a programmable out_clk and converts the
// driver's linear pixel index into column/row coordinates.
//   clock     : board clock (100 MHz)
//   reset     : synchronous, active-high
//   count_in  : divider terminal count (half-period = count_in+1 cycles)
//   out_clk   : divided clock
//   coord     : slave side of the coordinate bus (pix_index in; x, y, valid out)
// Build option: IDX_TO_COORD_REG_EN registers x, y and valid (1-cycle latency,
// cleared by reset). Undefined, the coordinate path is combinational and reset
// only touches the divider.
module idx_to_coord
  import oled_pkg::*;
#(
  parameter int unsigned WIDTH  = OLED_WIDTH,
  parameter int unsigned HEIGHT = OLED_HEIGHT,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  output logic             out_clk,
  idx_to_coord_if.slave    coord
);

  localparam logic [PIX_IDX_W-1:0] WidthC = PIX_IDX_W'(WIDTH);

  flexible_clock #(
    .CNT_W(CNT_W)
  ) u_div (
    .basys_clk(clock),
    .reset    (reset),
    .count_in (count_in),
    .out_clk  (out_clk)
  );

  logic [COORD_W-1:0] x_d, y_d;
  logic               valid_d;

  // Division by a constant: synthesis folds this into fixed logic, exact for
  // every index including the out-of-range ones.
  always_comb begin
    x_d     = COORD_W'(coord.pix_index % WidthC);
    y_d     = COORD_W'(coord.pix_index / WidthC);
    valid_d = (32'(coord.pix_index) < WIDTH * HEIGHT);
  end

`ifdef IDX_TO_COORD_REG_EN
  logic [COORD_W-1:0] x_q, y_q;
  logic               valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign coord.x     = x_q;
  assign coord.y     = y_q;
  assign coord.valid = valid_q;
`else
  assign coord.x     = x_d;
  assign coord.y     = y_d;
  assign coord.valid = valid_d;
`endif

endmodule

// File: tb/tb_idx_to_coord.sv
// Self-checking bench for idx_to_coord: divider timing, reset behaviour and
// index-to-coordinate conversion (directed vectors plus full index sweep).
module tb_idx_to_coord;
  import oled_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] count_in;
  logic        out_clk;

  idx_to_coord_if coord_bus ();

  idx_to_coord #(
    .WIDTH (OLED_WIDTH),
    .HEIGHT(OLED_HEIGHT),
    .CNT_W (32)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .count_in(count_in),
    .out_clk (out_clk),
    .coord   (coord_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Edges until out_clk changes; -1 if the budget expires.
  task automatic wait_toggle(input int budget, output int n);
    logic prev;
    prev = out_clk;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock);
      #1;
      if (out_clk !== prev) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    step(cycles);
    reset = 1'b0;
  endtask

  // Apply an index and wait for the coordinate path to reflect it.
  task automatic apply_pix(input logic [12:0] idx);
    coord_bus.pix_index = idx;
`ifdef IDX_TO_COORD_REG_EN
    step(1);
`else
    #1;
`endif
  endtask

  typedef struct {
    logic [12:0] idx;
    logic [12:0] ex;
    logic [12:0] ey;
    logic        ev;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int highs;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    count_in = 32'(CNT_6P25M);
    coord_bus.pix_index = 13'd100;

    // Reset hold, count_in = 7.
    step(3);
    check_eq("rst_out_clk", 32'(out_clk), 0);
    check_eq("rst_cnt", dut.u_div.cnt_q, 0);
`ifdef IDX_TO_COORD_REG_EN
    check_eq("rst_x", 32'(coord_bus.x), 0);
    check_eq("rst_y", 32'(coord_bus.y), 0);
    check_eq("rst_valid", 32'(coord_bus.valid), 0);
`endif
    reset = 1'b0;
    wait_toggle(40, n);
    check_eq("c7_first_rise", n, 8);
    check_eq("c7_level_hi", 32'(out_clk), 1);
    wait_toggle(40, n);
    check_eq("c7_fall", n, 8);
    wait_toggle(40, n);
    check_eq("c7_rise2", n, 8);
    // Reset while out_clk is high.
    do_reset(1);
    check_eq("rst_hi_out_clk", 32'(out_clk), 0);
    check_eq("rst_hi_cnt", dut.u_div.cnt_q, 0);

    // count_in = 0: toggle every cycle.
    count_in = 32'd0;
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      wait_toggle(10, n);
      check_eq("c0_toggle", n, 1);
    end

    // Lower count_in below the running count.
    count_in = 32'd100;
    do_reset(1);
    step(50);
    check_eq("c100_cnt50", dut.u_div.cnt_q, 50);
    count_in = 32'd3;
    wait_toggle(10, n);
    check_eq("lower_wrap", n, 1);
    wait_toggle(20, n);
    check_eq("lower_then4a", n, 4);
    wait_toggle(20, n);
    check_eq("lower_then4b", n, 4);

    // 200 Hz count: reset mid half-period restarts from zero.
    count_in = 32'(CNT_200HZ);
    do_reset(1);
    step(1000);
    check_eq("c200_cnt1000", dut.u_div.cnt_q, 1000);
    reset = 1'b1;
    step(2);
    check_eq("c200_rst_cnt", dut.u_div.cnt_q, 0);
    check_eq("c200_rst_clk", 32'(out_clk), 0);
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 20000; i++) begin
      step(1);
      if (out_clk !== 1'b0) highs++;
    end
    check_eq("c200_no_early", highs, 0);
    check_eq("c200_cnt20000", dut.u_div.cnt_q, 20000);
    // Drop to 4999 while cnt = 20000: immediate wrap.
    count_in = 32'd4999;
    wait_toggle(10, n);
    check_eq("c4999_wrap", n, 1);
    // Reset mid half-period; first toggle count_in+1 cycles after release.
    step(2000);
    do_reset(2);
    check_eq("c4999_rst_clk", 32'(out_clk), 0);
    wait_toggle(10000, n);
    check_eq("c4999_first", n, 5000);

    // Directed coordinate vectors.
    vecs[0] = '{13'd0,    13'd0,  13'd0,  1'b1};
    vecs[1] = '{13'd95,   13'd95, 13'd0,  1'b1};
    vecs[2] = '{13'd96,   13'd0,  13'd1,  1'b1};
    vecs[3] = '{13'd6143, 13'd95, 13'd63, 1'b1};
    vecs[4] = '{13'd6144, 13'd0,  13'd64, 1'b0};
    vecs[5] = '{13'd8191, 13'd31, 13'd85, 1'b0};
    foreach (vecs[i]) begin
      apply_pix(vecs[i].idx);
      check_eq($sformatf("x[%0d]", vecs[i].idx), 32'(coord_bus.x), 32'(vecs[i].ex));
      check_eq($sformatf("y[%0d]", vecs[i].idx), 32'(coord_bus.y), 32'(vecs[i].ey));
      check_eq($sformatf("v[%0d]", vecs[i].idx), 32'(coord_bus.valid), 32'(vecs[i].ev));
    end

`ifdef IDX_TO_COORD_REG_EN
    // One-cycle latency: old value visible until the next edge.
    apply_pix(13'd200);
    coord_bus.pix_index = 13'd300;
    #1;
    check_eq("lat_old_x", 32'(coord_bus.x), 8);
    check_eq("lat_old_y", 32'(coord_bus.y), 2);
    step(1);
    check_eq("lat_new_x", 32'(coord_bus.x), 12);
    check_eq("lat_new_y", 32'(coord_bus.y), 3);
`endif

    // Full sweep against the mod/div model.
    for (int i = 0; i < 8192; i++) begin
      apply_pix(13'(i));
      check_eq($sformatf("sweep_x[%0d]", i), 32'(coord_bus.x), 32'(i % 96));
      check_eq($sformatf("sweep_y[%0d]", i), 32'(coord_bus.y), 32'(i / 96));
      check_eq($sformatf("sweep_v[%0d]", i), 32'(coord_bus.valid), (i < 6144) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
